uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 29 ++
 rtl/rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry,
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_e;

    localparam int UART_NBIT_DATA = 8;
    localparam int UART_NUM_TICKS = 16;

    // Counter width for a modulus-n counter, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bus: oversampling tick and serial line in,
// received word with done/framing-error pulses out.
interface uart_rx_if #(
    parameter int NBIT_DATA = 8
) ();

    logic                 tick;
    logic                 rx_bit;
    logic [NBIT_DATA-1:0] data_out;
    logic                 rx_done_tick;
    logic                 rx_frame_err;

    modport master (
        output tick,
        output rx_bit,
        input  data_out,
        input  rx_done_tick,
        input  rx_frame_err
    );

    modport slave (
        input  tick,
        input  rx_bit,
        output data_out,
        output rx_done_tick,
        output rx_frame_err
    );

endinterface

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop framing, LSB first.
// Define UART_RX_FRAMING_ERR_EN to report a zero stop bit on rx_frame_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NBIT_DATA = UART_NBIT_DATA,
    parameter int NUM_TICKS = UART_NUM_TICKS
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    localparam int TW = cnt_w(NUM_TICKS);
    localparam int BW = cnt_w(NBIT_DATA);

    localparam logic [TW-1:0] TCNT_MID = TW'(NUM_TICKS / 2 - 1);
    localparam logic [TW-1:0] TCNT_END = TW'(NUM_TICKS - 1);
    localparam logic [BW-1:0] BCNT_END = BW'(NBIT_DATA - 1);

    uart_state_e          state_q, state_n;
    logic [TW-1:0]        tcnt_q,  tcnt_n;
    logic [BW-1:0]        bcnt_q,  bcnt_n;
    logic [NBIT_DATA-1:0] shreg_q, shreg_n;
    logic [NBIT_DATA-1:0] dout_q,  dout_n;
    logic                 done_q,  done_n;
    logic                 rx_s;
`ifdef UART_RX_FRAMING_ERR_EN
    logic                 ferr_q,  ferr_n;
`endif

    rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx_bit),
        .q     (rx_s)
    );

    // Everything advances only on tick; done/ferr default low so they
    // are single-clk pulses no matter how far apart ticks are.
    always_comb begin
        state_n = state_q;
        tcnt_n  = tcnt_q;
        bcnt_n  = bcnt_q;
        shreg_n = shreg_q;
        dout_n  = dout_q;
        done_n  = 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
        ferr_n  = 1'b0;
`endif
        if (bus.tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_n = ST_START;
                        tcnt_n  = '0;
                    end
                end
                ST_START: begin
                    if (tcnt_q == TCNT_MID) begin
                        tcnt_n = '0;
                        bcnt_n = '0;
                        // A line back high at mid start bit was a glitch.
                        state_n = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_n = tcnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tcnt_q == TCNT_END) begin
                        tcnt_n  = '0;
                        shreg_n = {rx_s, shreg_q[NBIT_DATA-1:1]};
                        if (bcnt_q == BCNT_END) begin
                            state_n = ST_STOP;
                            bcnt_n  = '0;
                        end else begin
                            bcnt_n = bcnt_q + 1'b1;
                        end
                    end else begin
                        tcnt_n = tcnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tcnt_q == TCNT_END) begin
                        state_n = ST_IDLE;
                        tcnt_n  = '0;
                        bcnt_n  = '0;
                        dout_n  = shreg_q;
                        done_n  = 1'b1;
`ifdef UART_RX_FRAMING_ERR_EN
                        ferr_n  = ~rx_s;
`endif
                    end else begin
                        tcnt_n = tcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    tcnt_n  = '0;
                    bcnt_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            tcnt_q  <= tcnt_n;
            bcnt_q  <= bcnt_n;
            shreg_q <= shreg_n;
            dout_q  <= dout_n;
            done_q  <= done_n;
        end
    end

`ifdef UART_RX_FRAMING_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ferr_n;
        end
    end

    assign bus.rx_frame_err = ferr_q;
`else
    assign bus.rx_frame_err = 1'b0;
`endif

    assign bus.data_out     = dout_q;
    assign bus.rx_done_tick = done_q;

endmodule
